// File: rtl/shifter_32_bit_left_seq.sv
// shifter_32_bit_left_seq
// Iterative logical left shifter. An operand is captured in IDLE and shifted
// by up to STEP positions per clock in SHIFT. The result is then presented in
// DONE until the consumer takes it. Vacated low bits are filled with zero.
// Bits shifted out of the top are discarded.

module shifter_32_bit_left_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [SHAMT_W-1:0] i_shift_amt,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // STEP is at most WIDTH-1, so it always fits in the shift-amount field
  localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);

  logic [1:0]         state_q;
  logic [WIDTH-1:0]   data_q;
  logic [SHAMT_W-1:0] rem_q;
  logic [SHAMT_W-1:0] step_amt;
  logic [SHAMT_W-1:0] rem_next;

  // Shift this cycle by the smaller of what is left and the per-cycle step
  always_comb begin
    step_amt = STEP_K;
    if (rem_q < STEP_K) begin
      step_amt = rem_q;
    end
    rem_next = rem_q - step_amt;
  end

  // Handshake FSM plus the shifting data and remaining-count registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            data_q <= i_data;
            rem_q  <= i_shift_amt;
            if (i_shift_amt == '0) begin
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          data_q <= data_q << step_amt;
          rem_q  <= rem_next;
          if (rem_next == '0) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // The result is the data register itself; it is only meaningful with o_valid
  assign o_data  = data_q;
  assign o_ready = (state_q == ST_IDLE);
  assign o_valid = (state_q == ST_DONE);
  assign o_busy  = (state_q == ST_SHIFT) || (state_q == ST_DONE);

endmodule

// File: tb/tb_shifter_32_bit_left_seq.sv
// tb_shifter_32_bit_left_seq
// Directed vector table, hand-written backpressure and reset sequences, and a
// random sweep compared against i_data << amt. Latency is counted in clock
// edges from the edge that captures the operand to the first edge after which
// o_valid is high, which is ceil(amt/STEP).

module tb_shifter_32_bit_left_seq;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data;
  logic [4:0]  i_shift_amt;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic        o_busy;

  int checks;
  int errors;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  amt;
    logic [31:0] expected;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs [9];

  shifter_32_bit_left_seq #(.WIDTH(32), .STEP(4)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .i_shift_amt (i_shift_amt),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_busy      (o_busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %08h, expected %08h", name, actual, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge i_clk);
    #1;
  endtask

  // Run one complete transaction: wait for o_ready, capture, wait for the
  // result, hold it under backpressure for 'hold' cycles, then hand it off
  task automatic applyStimulus(input string name, input logic [31:0] d, input logic [4:0] a,
                               input logic [31:0] expected, input int lat, input int hold);
    int cyc;
    cyc = 0;
    while (!o_ready && cyc < 64) begin
      stepClock();
      cyc++;
    end
    checkOutput({name, " o_ready before"}, 32'(o_ready), 32'd1);
    i_data      = d;
    i_shift_amt = a;
    i_valid     = 1'b1;
    stepClock();
    i_valid     = 1'b0;
    i_data      = $urandom;
    i_shift_amt = 5'($urandom);
    cyc = 0;
    while (!o_valid && cyc < 64) begin
      checkOutput({name, " busy while shifting"}, 32'(o_busy), 32'd1);
      stepClock();
      cyc++;
    end
    checkOutput({name, " latency"}, 32'(cyc), 32'(lat));
    checkOutput({name, " data"}, o_data, expected);
    checkOutput({name, " busy in done"}, 32'(o_busy), 32'd1);
    for (int h = 0; h < hold; h++) begin
      stepClock();
      checkOutput({name, " held valid"}, 32'(o_valid), 32'd1);
      checkOutput({name, " held data"}, o_data, expected);
    end
    i_ready = 1'b1;
    stepClock();
    i_ready = 1'b0;
    checkOutput({name, " o_ready after"}, 32'(o_ready), 32'd1);
    checkOutput({name, " o_valid after"}, 32'(o_valid), 32'd0);
  endtask

  // Main test sequence
  initial begin
    logic [31:0] rd;
    logic [4:0]  ra;

    checks = 0;
    errors = 0;

    vecs[0] = '{32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 0, 0};
    vecs[1] = '{32'h00000001, 5'd31, 32'h80000000, 8, 0};
    vecs[2] = '{32'hF000000F, 5'd5,  32'h000001E0, 2, 1};
    vecs[3] = '{32'hFFFFFFFF, 5'd4,  32'hFFFFFFF0, 1, 0};
    vecs[4] = '{32'h12345678, 5'd16, 32'h56780000, 4, 2};
    vecs[5] = '{32'h80000001, 5'd1,  32'h00000002, 1, 0};
    vecs[6] = '{32'hA5A5A5A5, 5'd3,  32'h2D2D2D28, 1, 0};
    vecs[7] = '{32'h0000FFFF, 5'd30, 32'hC0000000, 8, 3};
    vecs[8] = '{32'h000000AB, 5'd8,  32'h0000AB00, 2, 0};

    i_rst_n     = 1'b0;
    i_valid     = 1'b1;
    i_data      = 32'hFFFFFFFF;
    i_shift_amt = 5'd3;
    i_ready     = 1'b0;
    #2;
    checkOutput("reset o_valid", 32'(o_valid), 32'd0);
    checkOutput("reset o_busy", 32'(o_busy), 32'd0);
    checkOutput("reset o_data", o_data, 32'h0);
    checkOutput("reset o_ready", 32'(o_ready), 32'd1);
    stepClock();
    checkOutput("no capture in reset", 32'(o_busy), 32'd0);
    i_valid = 1'b0;
    #3;
    i_rst_n = 1'b1;
    stepClock();

    for (int i = 0; i < 9; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].data, vecs[i].amt,
                    vecs[i].expected, vecs[i].lat, vecs[i].hold);
    end

    // Backpressure with a competing operand offered during DONE
    i_data      = 32'h000000AB;
    i_shift_amt = 5'd8;
    i_valid     = 1'b1;
    stepClock();
    i_valid     = 1'b0;
    repeat (2) stepClock();
    checkOutput("bp valid", 32'(o_valid), 32'd1);
    i_data      = 32'h00000001;
    i_shift_amt = 5'd1;
    i_valid     = 1'b1;
    for (int h = 0; h < 4; h++) begin
      stepClock();
      checkOutput("bp held data", o_data, 32'h0000AB00);
      checkOutput("bp held valid", 32'(o_valid), 32'd1);
      checkOutput("bp ready low", 32'(o_ready), 32'd0);
    end
    i_ready = 1'b1;
    stepClock();
    i_ready = 1'b0;
    checkOutput("bp new op not taken", 32'(o_ready), 32'd1);
    checkOutput("bp idle not busy", 32'(o_busy), 32'd0);
    stepClock();
    i_valid = 1'b0;
    checkOutput("bp new op shifting", 32'(o_busy), 32'd1);
    stepClock();
    checkOutput("bp new op valid", 32'(o_valid), 32'd1);
    checkOutput("bp new op data", o_data, 32'h00000002);
    i_ready = 1'b1;
    stepClock();
    i_ready = 1'b0;

    // Asynchronous reset in the middle of a shift
    i_data      = 32'h12345678;
    i_shift_amt = 5'd20;
    i_valid     = 1'b1;
    stepClock();
    i_valid = 1'b0;
    repeat (2) stepClock();
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("mid reset o_valid", 32'(o_valid), 32'd0);
    checkOutput("mid reset o_busy", 32'(o_busy), 32'd0);
    checkOutput("mid reset o_data", o_data, 32'h0);
    #3;
    i_rst_n = 1'b1;
    stepClock();
    applyStimulus("after reset", 32'h00000001, 5'd4, 32'h00000010, 1, 0);

    // Random sweep with random idle gaps and consumer stalls
    for (int i = 0; i < 1000; i++) begin
      rd = $urandom;
      ra = 5'($urandom_range(0, 31));
      repeat ($urandom_range(0, 2)) stepClock();
      applyStimulus("rand", rd, ra, rd << ra, (int'(ra) + 3) / 4, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shifter_32_bit_left_seq.md
Name: shifter_32_bit_left_seq

Overview:
- Multi-cycle logical left shifter (SLL/SLLI semantics) with valid/ready handshakes on both the input and output sides.
- The shift is performed STEP bits per cycle in an iterative datapath, trading latency for area against a full barrel shifter.
- Fills vacated low bits with zero; there is no arithmetic mode for left shifts.
- Sits beside the ALU as the left-shift execution unit. The control path stalls on o_ready/o_valid.

Parameters:
- WIDTH, 32, data width in bits; the shift-amount width is $clog2(WIDTH) (5 at default).
- STEP, 4, maximum bit positions shifted per cycle; legal range 1..WIDTH-1.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_valid  input  1  input operand valid.
- o_ready  output  1  block can accept an operand this cycle.
- i_data  input  WIDTH  operand to shift.
- i_shift_amt  input  $clog2(WIDTH)  shift amount, unsigned.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts result this cycle.
- o_data  output  WIDTH  shifted result.
- o_busy  output  1  high in SHIFT or DONE.

Behaviour:
- One clock; reset is asynchronous and active-low (i_clk, i_rst_n).
- Reset (i_rst_n low, any state, including mid-shift):
  - state=IDLE; data register, remaining-count register and o_data clear to 0.
  - o_valid=0, o_busy=0.
  - No operand is captured while reset is asserted.
  - Operation resumes on the first rising edge after deassertion.
- States: IDLE, SHIFT, DONE. o_ready=1 only in IDLE; o_valid=1 only in DONE.
- IDLE:
  - Accept when i_valid & o_ready at an edge: capture i_data into the data register and i_shift_amt into the remaining register.
  - If i_shift_amt==0, go to DONE; otherwise go to SHIFT.
  - i_valid without acceptance has no effect.
- SHIFT, per cycle:
  - k = min(remaining, STEP).
  - data <= data << k, zero fill; remaining <= remaining - k.
  - When remaining - k == 0, go to DONE.
  - i_valid is ignored; i_data/i_shift_amt may change freely.
- DONE:
  - o_data drives the data register, stable while o_valid=1.
  - On i_ready=1, transfer completes and state goes to IDLE.
  - While i_ready=0, hold indefinitely (backpressure).
- o_data outside DONE: holds the last data register value. It is not qualified; consumers sample only with o_valid.
- Latency: accept at edge T gives o_valid high from edge T+1+ceil(amt/STEP).
  - amt=0: T+1.
  - amt=31, STEP=4: T+9.
- Throughput: no overlap. A new operand can be accepted at the earliest one cycle after the DONE handshake, since o_ready is low in the DONE cycle.
- Arithmetic: shifted-out high bits are discarded; no carry or overflow output.
  - Shift amount is interpreted modulo WIDTH by construction (5-bit field).
  - Result equals i_data << i_shift_amt truncated to WIDTH bits.
- Simultaneous i_valid and i_ready in DONE: the result handshake completes and the operand is NOT accepted. The producer must hold i_valid until it sees o_ready.
- STEP=1 degenerates to a bit-serial shifter. STEP>=WIDTH-1 always completes in one SHIFT cycle.

Test Plan:
- Pass-through: i_data=0xDEADBEEF, amt=0, accepted at T -> o_valid at T+1, o_data=0xDEADBEEF; i_ready=1 returns to IDLE with o_ready=1 at T+2.
- Full shift: i_data=0x00000001, amt=31, STEP=4 -> 8 SHIFT cycles (4×7 + 3); o_valid at T+9, o_data=0x80000000.
- Partial step and zero fill: i_data=0xF000000F, amt=5 -> SHIFT by 4 then 1; o_valid at T+3, o_data=0x000001E0.
- Backpressure: complete amt=8 on 0x000000AB with i_ready=0 for 4 cycles -> o_data=0x0000AB00 held stable, o_valid=1, o_ready=0. Concurrent i_valid with new operand 0x1/amt=1 is not accepted. After i_ready=1, the new operand is accepted and yields 0x00000002.
- Reset mid-operation: accept 0x12345678, amt=20; assert i_rst_n=0 asynchronously after 2 SHIFT cycles -> o_valid=0, o_busy=0, o_data=0 immediately (no clock edge). After release, amt=4 on 0x00000001 gives 0x00000010 with nominal latency T+2.
- Randomised sweep: 1000 random (i_data, amt) pairs with random i_valid/i_ready gaps -> every result equals (i_data << amt) truncated to 32 bits, latency matches the formula, and no operand is lost or duplicated.
